// File: rtl/pid_pkg.sv
// Shared widths, ramp constants and the 12b signed speed clamp for the heading PID chain.
package pid_pkg;
    localparam int P_W     = 14;
    localparam int I_W     = 12;
    localparam int D_W     = 13;
    localparam int SPD_W   = 12;
    localparam int FRWRD_W = 11;
    localparam int ERR_W   = 10;
    localparam int SUM_W   = 15;

    localparam logic [FRWRD_W-1:0] FAST_INC  = 11'd18;
    localparam logic [FRWRD_W-1:0] SLOW_INC  = 11'd2;
    localparam logic [FRWRD_W-1:0] DEC       = 11'd36;
    localparam logic [FRWRD_W-1:0] MAX_FRWRD = 11'h2A0;
    // Compared against |err_sat| in 11b so that -512 maps to +512.
    localparam logic [ERR_W:0]     ERR_SMALL = 11'd96;

    function automatic logic signed [SPD_W-1:0] clamp_spd(input logic signed [SPD_W:0] v);
        if (v > 13'sd2047)
            return 12'sd2047;
        else if (v < -13'sd2048)
            return -12'sd2048;
        else
            return v[SPD_W-1:0];
    endfunction
endpackage

// File: rtl/frwrd_ramp.sv
// Forward-speed ramp: accelerates fast or slow depending on heading error, decays when stopped.
module frwrd_ramp
    import pid_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hdng_vld,
    input  logic                     moving,
    input  logic signed [ERR_W-1:0]  err_sat,
    output logic [FRWRD_W-1:0]       frwrd
);
    logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
    logic [ERR_W:0]     err_ext, err_abs;
    logic [FRWRD_W-1:0] inc;
    logic [FRWRD_W:0]   inc_sum;

    always_comb begin
        err_ext = {err_sat[ERR_W-1], err_sat};
        err_abs = err_sat[ERR_W-1] ? (~err_ext + 11'd1) : err_ext;
        inc     = (err_abs < ERR_SMALL) ? FAST_INC : SLOW_INC;
        inc_sum = {1'b0, frwrd_q} + {1'b0, inc};
        frwrd_d = frwrd_q;
        if (hdng_vld) begin
            if (moving)
                frwrd_d = (inc_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : inc_sum[FRWRD_W-1:0];
            else
                frwrd_d = (frwrd_q < DEC) ? '0 : frwrd_q - DEC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            frwrd_q <= '0;
        else
            frwrd_q <= frwrd_d;
    end

    assign frwrd = frwrd_q;
endmodule

// File: rtl/pid_speed_mixer.sv
// Mixes P/I/D terms around the ramped forward speed into clamped left/right motor speeds.
module pid_speed_mixer
    import pid_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hdng_vld,
    input  logic                    moving,
    input  logic signed [ERR_W-1:0] err_sat,
    input  logic signed [P_W-1:0]   P_term,
    input  logic signed [I_W-1:0]   I_term,
    input  logic signed [D_W-1:0]   D_term,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    spd_vld
);
    logic [FRWRD_W-1:0]      frwrd;
    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic                    mov_q, v1_q, vld_q;
    logic signed [SPD_W-1:0] scaled;
    logic signed [SPD_W:0]   scaled_ext, f13, lft_sum, rght_sum;
    logic signed [SPD_W-1:0] lft_d, rght_d, lft_q, rght_q;

    frwrd_ramp u_ramp (
        .clk      (clk),
        .rst_n    (rst_n),
        .hdng_vld (hdng_vld),
        .moving   (moving),
        .err_sat  (err_sat),
        .frwrd    (frwrd)
    );

    // Stage 2 reads frwrd after the stage-1 edge, i.e. the value already updated for this strobe.
    always_comb begin
        sum_d      = SUM_W'(P_term) + SUM_W'(I_term) + SUM_W'(D_term);
        scaled     = SPD_W'(sum_q >>> 3);
        scaled_ext = {scaled[SPD_W-1], scaled};
        f13        = signed'({2'b00, frwrd});
        lft_sum    = f13 + scaled_ext;
        rght_sum   = f13 - scaled_ext;
        lft_d      = mov_q ? clamp_spd(lft_sum) : '0;
        rght_d     = mov_q ? clamp_spd(rght_sum) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            mov_q  <= 1'b0;
            v1_q   <= 1'b0;
            vld_q  <= 1'b0;
            lft_q  <= '0;
            rght_q <= '0;
        end else begin
            v1_q  <= hdng_vld;
            vld_q <= v1_q;
            if (hdng_vld) begin
                sum_q <= sum_d;
                mov_q <= moving;
            end
            if (v1_q) begin
                lft_q  <= lft_d;
                rght_q <= rght_d;
            end
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign spd_vld  = vld_q;
endmodule
